// File: rtl/fpga_cfg_loader_if.sv
// Bitstream byte channel between the pin wrapper (master) and the config loader (slave).
// Transfer happens on a rising clk edge where byte_valid and byte_ready are both high.
interface fpga_cfg_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/fpga_cfg_loader.sv
// Loads a CHAIN_LEN-bit bitstream, byte by byte and LSB first, into the fabric's serial
// config chain, strobes the latch once, then enables the fabric.
module fpga_cfg_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    fpga_cfg_loader_if.slave bus,
    output logic             cfg_data,
    output logic             cfg_shift,
    output logic             cfg_latch,
    output logic             fabric_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);

    state_t           state_q;
    logic [CNT_W-1:0] bitcnt_q;
    logic [CNT_W-1:0] bitcnt_d;
    logic [2:0]       idx_q;
    logic [7:0]       shreg_q;
    logic             cfg_data_q;
    logic             cfg_shift_q;
    logic             cfg_latch_q;
    logic             fabric_en_q;
    logic             busy_q;

    assign bitcnt_d = bitcnt_q + CNT_W'(1);

    // Only control that is visible to the source: gated by ena so a frozen loader never consumes a byte.
    assign bus.byte_ready = ena && (state_q == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            cfg_data_q  <= 1'b0;
            cfg_shift_q <= 1'b0;
            cfg_latch_q <= 1'b0;
            fabric_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (!ena) begin
            cfg_shift_q <= 1'b0;
            cfg_latch_q <= 1'b0;
        end else begin
            cfg_shift_q <= 1'b0;
            cfg_latch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.byte_valid) begin
                        shreg_q <= bus.byte_in;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cfg_data_q  <= shreg_q[idx_q];
                    cfg_shift_q <= 1'b1;
                    idx_q       <= idx_q + 3'd1;
                    bitcnt_q    <= bitcnt_d;
                    // Chain full wins over byte boundary: leftover bits of a short final byte are dropped.
                    if (bitcnt_d == LAST_BIT) begin
                        state_q <= LATCH;
                    end else if (idx_q == 3'd7) begin
                        state_q <= LOAD;
                    end
                end
                LATCH: begin
                    cfg_latch_q <= 1'b1;
                    fabric_en_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    if (start) begin
                        state_q     <= LOAD;
                        bitcnt_q    <= '0;
                        fabric_en_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_data  = cfg_data_q;
    assign cfg_shift = cfg_shift_q;
    assign cfg_latch = cfg_latch_q;
    assign fabric_en = fabric_en_q;
    assign busy      = busy_q;
    assign done      = fabric_en_q;

endmodule
